// File: rtl/shift_retire.sv
// Retire stage behind a fixed-latency shift unit: tag pipeline, result FIFO, credit-gated issue.
// Optional: define SHIFT_RETIRE_X0_DROP_EN to discard results destined for x0.
module shift_retire #(
    parameter int DEPTH      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,
    input  logic [31:0] shift_result,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    input  logic        wb_ready
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DEPTH-1:0] tag_v;
    logic [4:0]       tag_rd [DEPTH];
    logic [4:0]       mem_rd [FIFO_DEPTH];
    logic [31:0]      mem_data [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    credits_used;
    logic             accept;
    logic             capture;
    logic             drop;
    logic             push;
    logic             pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign accept  = issue_valid && issue_ready;
    assign capture = tag_v[DEPTH-1];

`ifdef SHIFT_RETIRE_X0_DROP_EN
    assign drop = capture && (tag_rd[DEPTH-1] == 5'd0);
`else
    assign drop = 1'b0;
`endif

    assign push        = capture && !drop;
    assign wb_valid    = (count != '0);
    assign pop         = wb_valid && wb_ready;
    assign issue_ready = (credits_used < CW'(FIFO_DEPTH));
    // Outputs read zero when empty so the reset state is defined without clearing storage.
    assign wb_rd       = wb_valid ? mem_rd[rd_ptr] : '0;
    assign wb_data     = wb_valid ? mem_data[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                tag_rd[k] <= '0;
            end
        end else begin
            tag_v[0]  <= accept;
            tag_rd[0] <= issue_rd;
            for (int k = 1; k < DEPTH; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_rd[k] <= tag_rd[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr]   <= tag_rd[DEPTH-1];
            mem_data[wr_ptr] <= shift_result;
        end
    end

    // Credits cover every accepted op from issue until pop (or x0 drop), so pushes never overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            credits_used <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count        <= count + CW'(push) - CW'(pop);
            credits_used <= credits_used + CW'(accept) - CW'(pop) - CW'(drop);
        end
    end

    assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (count == CW'(FIFO_DEPTH))));

endmodule
